// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester ids
// and the byte-to-word address shift.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    localparam logic CPU        = 1'b0;
    localparam logic DMA        = 1'b1;
    localparam int   WORD_SHIFT = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: a lone requester always wins, and on a tie
// the port that did not win the previous tie is chosen.
module rr_arb2
    import dm_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = (last_grant == CPU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA port,
// holding each access for MEM_LAT cycles. Optional: DM_ALIGN_CHECK_EN adds align_err.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 3074,
    parameter int MEM_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_last, w_last_next;
    logic                r_we, w_we_next;
    logic                r_ok, w_ok_next;
    logic [ADDR_W-1:0]   r_idx, w_idx_next;
    logic [DATA_W-1:0]   r_wdata, w_wdata_next;

    logic [1:0]          w_grant;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [ADDR_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_ok;
    logic                w_busy;
    logic                w_finish;
    logic                w_port;

    rr_arb2 u_arb (
        .req        ({dma_req, cpu_req}),
        .last_grant (r_last),
        .grant      (w_grant)
    );

    assign w_sel_we    = w_grant[DMA] ? dma_we    : cpu_we;
    assign w_sel_addr  = w_grant[DMA] ? dma_addr  : cpu_addr;
    assign w_sel_wdata = w_grant[DMA] ? dma_wdata : cpu_wdata;
    assign w_sel_idx   = w_sel_addr >> WORD_SHIFT;

`ifdef DM_ALIGN_CHECK_EN
    logic w_sel_misal;
    logic r_misal, w_misal_next;
    logic r_align_err;
    assign w_sel_misal = |w_sel_addr[1:0];
    assign w_sel_ok    = (w_sel_idx < ADDR_W'(DEPTH_WORDS)) && !w_sel_misal;
`else
    assign w_sel_ok    = (w_sel_idx < ADDR_W'(DEPTH_WORDS));
`endif

    assign w_busy   = (r_state != IDLE);
    assign w_finish = w_busy && (r_cnt == '0);
    assign w_port   = (r_state == BUSY_DMA) ? DMA : CPU;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_last_next  = r_last;
        w_we_next    = r_we;
        w_ok_next    = r_ok;
        w_idx_next   = r_idx;
        w_wdata_next = r_wdata;
`ifdef DM_ALIGN_CHECK_EN
        w_misal_next = r_misal;
`endif
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_state_next = w_grant[DMA] ? BUSY_DMA : BUSY_CPU;
                    w_cnt_next   = CNT_W'(MEM_LAT - 1);
                    w_we_next    = w_sel_we;
                    w_ok_next    = w_sel_ok;
                    w_idx_next   = w_sel_idx;
                    w_wdata_next = w_sel_wdata;
`ifdef DM_ALIGN_CHECK_EN
                    w_misal_next = w_sel_misal;
`endif
                    // Priority only flips on an actual tie, so a solo access
                    // never robs the previous tie's loser of its turn.
                    if (cpu_req && dma_req) begin
                        w_last_next = w_grant[DMA];
                    end
                end
            end
            default: begin
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= DMA;
            r_we    <= 1'b0;
            r_ok    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
            r_we    <= w_we_next;
            r_ok    <= w_ok_next;
            r_idx   <= w_idx_next;
            r_wdata <= w_wdata_next;
        end
    end

    // Gating with reset keeps a store that is being aborted from reaching the array.
    assign mem_en    = w_busy && r_ok && !reset;
    assign mem_we    = w_busy && r_ok && r_we && (r_cnt == '0) && !reset;
    assign mem_addr  = r_idx;
    assign mem_wdata = r_wdata;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] r_rdata;
        logic              r_done;
        logic              w_mine;

        assign w_mine = w_finish && (w_port == 1'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
                r_done  <= 1'b0;
            end else begin
                r_done <= w_mine;
                if (w_mine && !r_we) begin
                    r_rdata <= r_ok ? mem_rdata : '0;
                end
            end
        end
    end

    assign cpu_rdata = g_port[0].r_rdata;
    assign cpu_done  = g_port[0].r_done;
    assign dma_rdata = g_port[1].r_rdata;
    assign dma_done  = g_port[1].r_done;
    assign cpu_stall = cpu_req && !cpu_done;

`ifdef DM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misal     <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_misal     <= w_misal_next;
            r_align_err <= w_finish && r_misal;
        end
    end
    assign align_err = r_align_err;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: scripted and random traffic on both
// ports against a transaction-level model of arbitration, latency and memory.
module tb_dm_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 3074;
    localparam int LAT   = 2;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_done, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_done;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DM_ALIGN_CHECK_EN
    logic          align_err;
`endif

    dm_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DM_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array environment; junk on the read bus whenever it is not enabled.
    logic [DW-1:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we && mem_addr < DEPTH) env_mem[mem_addr[11:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_en && mem_addr < DEPTH) ? env_mem[mem_addr[11:0]] : 32'hA5A5_5A5A;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; int gap; } op_t;
    typedef struct { int port; int cyc; logic [31:0] rdata; } ev_t;

    op_t           q_cpu[$], q_dma[$];
    ev_t           obs[$], expq[$];
    int            we_k[$];
    logic [31:0]   we_a[$], we_d[$];
    int            align_k[$];
    int            en_cnt, stall_bad, stall_hi;
    bit            timed_out;
    logic [31:0]   ref_mem[int];
    logic [31:0]   mdl_rd[2];
    bit            ref_last;
    int            checks, failures;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit r, input op_t o);
        if (p == 0) begin
            cpu_req = r; cpu_we = o.we; cpu_addr = o.addr; cpu_wdata = o.data;
        end else begin
            dma_req = r; dma_we = o.we; dma_addr = o.addr; dma_wdata = o.data;
        end
    endtask

    // Reference: applies a granted access to the model memory and predicts its completion.
    task automatic model_access(input int p, input op_t o, input int dcyc);
        int idx;
        bit ok;
        idx = int'(o.addr >> 2);
        ok  = (o.addr >> 2) < DEPTH;
`ifdef DM_ALIGN_CHECK_EN
        ok  = ok && (o.addr % 4 == 0);
`endif
        if (o.we) begin
            if (ok) ref_mem[idx] = o.data;
        end else begin
            mdl_rd[p] = (ok && ref_mem.exists(idx)) ? ref_mem[idx] : 32'h0;
        end
        expq.push_back('{p, dcyc, mdl_rd[p]});
    endtask

    // Plays the queued operations on both ports, logging what the DUT does and
    // what the model predicts; cycle 0 is the cycle the run starts in.
    task automatic run_ops(input int max_cyc);
        bit  req_l[2];
        int  gapc[2];
        op_t cur[2];
        int  next_free;
        int  win;
        bit  finished;
        obs.delete(); expq.delete(); we_k.delete(); we_a.delete(); we_d.delete(); align_k.delete();
        en_cnt = 0; stall_bad = 0; stall_hi = 0; timed_out = 0;
        req_l = '{0, 0}; gapc = '{0, 0}; next_free = 0; finished = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (!req_l[0] && q_cpu.size() > 0) begin
                if (gapc[0] >= q_cpu[0].gap) begin
                    cur[0] = q_cpu.pop_front(); req_l[0] = 1; gapc[0] = 0; drive(0, 1, cur[0]);
                end else gapc[0]++;
            end
            if (!req_l[1] && q_dma.size() > 0) begin
                if (gapc[1] >= q_dma[0].gap) begin
                    cur[1] = q_dma.pop_front(); req_l[1] = 1; gapc[1] = 0; drive(1, 1, cur[1]);
                end else gapc[1]++;
            end
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (mem_we) begin we_k.push_back(k); we_a.push_back(mem_addr); we_d.push_back(mem_wdata); end
`ifdef DM_ALIGN_CHECK_EN
            if (align_err) align_k.push_back(k);
`endif
            if (cpu_req && !cpu_done) stall_hi++;
            if (cpu_stall !== (cpu_req && !cpu_done)) stall_bad++;
            if (cpu_done) begin
                obs.push_back('{0, k, cpu_rdata});
                $display("txn port=cpu cyc=%0d we=%0d addr=%h rdata=%h", k, cur[0].we, cur[0].addr, cpu_rdata);
                if (req_l[0]) begin req_l[0] = 0; cpu_req = 1'b0; end
            end
            if (dma_done) begin
                obs.push_back('{1, k, dma_rdata});
                $display("txn port=dma cyc=%0d we=%0d addr=%h rdata=%h", k, cur[1].we, cur[1].addr, dma_rdata);
                if (req_l[1]) begin req_l[1] = 0; dma_req = 1'b0; end
            end
            if (k >= next_free && (req_l[0] || req_l[1])) begin
                if (req_l[0] && req_l[1]) begin
                    win = ref_last ? 0 : 1;
                    ref_last = (win == 1);
                end else begin
                    win = req_l[0] ? 0 : 1;
                end
                model_access(win, cur[win], k + LAT + 1);
                next_free = k + LAT + 1;
            end
            if (!req_l[0] && !req_l[1] && q_cpu.size() == 0 && q_dma.size() == 0 && k >= next_free) begin
                finished = 1;
                break;
            end
            tick();
        end
        if (!finished) begin
            timed_out = 1;
            cpu_req = 1'b0; dma_req = 1'b0;
            q_cpu.delete(); q_dma.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rst_cpu_rdata got=%h want=0", cpu_rdata); end
        checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL rst_dma_rdata got=%h want=0", dma_rdata); end
        checks++; if (cpu_done !== 1'b0) begin failures++; $display("FAIL rst_cpu_done got=%b want=0", cpu_done); end
        checks++; if (dma_done !== 1'b0) begin failures++; $display("FAIL rst_dma_done got=%b want=0", dma_done); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_cpu_stall got=%b want=0", cpu_stall); end
        tick();
        reset = 1'b0;
        mdl_rd = '{32'h0, 32'h0};
        ref_last = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        q_cpu.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 0});
        run_ops(40);
        checks++; if (timed_out || obs.size() != 1) begin failures++; $display("FAIL st_count got=%0d want=1", obs.size()); end
        else begin
            checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL st_done_cyc got=%0d want=3", obs[0].cyc); end
        end
        checks++; if (we_k.size() != 1) begin failures++; $display("FAIL st_we_cycles got=%0d want=1", we_k.size()); end
        else begin
            checks++; if (we_k[0] != 2) begin failures++; $display("FAIL st_we_cyc got=%0d want=2", we_k[0]); end
            checks++; if (we_a[0] !== 32'd4) begin failures++; $display("FAIL st_we_addr got=%h want=4", we_a[0]); end
            checks++; if (we_d[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL st_we_data got=%h want=deadbeef", we_d[0]); end
        end
        q_cpu.push_back('{1'b0, 32'h10, 32'h0, 0});
        run_ops(40);
        checks++; if (timed_out || obs.size() != 1) begin failures++; $display("FAIL ld_count got=%0d want=1", obs.size()); end
        else begin
            checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL ld_done_cyc got=%0d want=3", obs[0].cyc); end
            checks++; if (obs[0].rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_rdata got=%h want=deadbeef", obs[0].rdata); end
        end
        checks++; if (we_k.size() != 0) begin failures++; $display("FAIL ld_no_write got=%0d want=0", we_k.size()); end
    endtask

    task automatic test_tie();
        int first_exp;
        for (int r = 0; r < 3; r++) begin
            first_exp = (r == 1) ? 1 : 0;
            q_cpu.push_back('{1'b0, 32'h14, 32'h0, 0});
            q_dma.push_back('{1'b0, 32'h18, 32'h0, 0});
            run_ops(40);
            checks++; if (timed_out || obs.size() != 2) begin failures++; $display("FAIL tie%0d_count got=%0d want=2", r, obs.size()); end
            else begin
                checks++; if (obs[0].port != first_exp) begin failures++; $display("FAIL tie%0d_winner got=%0d want=%0d", r, obs[0].port, first_exp); end
                checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL tie%0d_first_cyc got=%0d want=3", r, obs[0].cyc); end
                checks++; if (obs[1].cyc != 6) begin failures++; $display("FAIL tie%0d_second_cyc got=%0d want=6", r, obs[1].cyc); end
            end
        end
    endtask

    task automatic test_dma_burst();
        logic [31:0] wv[4];
        int cpu_i, last_dma;
        for (int i = 0; i < 4; i++) begin
            wv[i] = $urandom | 32'h1;
            q_dma.push_back('{1'b1, 32'(i * 4), wv[i], 0});
        end
        q_cpu.push_back('{1'b0, 32'h8, 32'h0, 9});
        run_ops(80);
        cpu_i = -1; last_dma = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].port == 0) cpu_i = i;
            else last_dma = obs[i].cyc;
        end
        checks++; if (timed_out || cpu_i < 0) begin failures++; $display("FAIL burst_cpu_seen got=%0d want=1", cpu_i >= 0); end
        else begin
            checks++; if (obs[cpu_i].cyc != 14) begin failures++; $display("FAIL burst_cpu_cyc got=%0d want=14", obs[cpu_i].cyc); end
            checks++; if (obs[cpu_i].rdata !== wv[2]) begin failures++; $display("FAIL burst_cpu_rdata got=%h want=%h", obs[cpu_i].rdata, wv[2]); end
        end
        checks++; if (last_dma != 17) begin failures++; $display("FAIL burst_dma_last got=%0d want=17", last_dma); end
        checks++; if (stall_hi != 5) begin failures++; $display("FAIL burst_stall_cycles got=%0d want=5", stall_hi); end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL burst_stall_bad got=%0d want=0", stall_bad); end
    endtask

    task automatic test_out_of_range();
        q_cpu.push_back('{1'b1, 32'(4 * DEPTH), 32'h12345678, 0});
        run_ops(40);
        checks++; if (we_k.size() != 0) begin failures++; $display("FAIL oor_st_write got=%0d want=0", we_k.size()); end
        checks++; if (en_cnt != 0) begin failures++; $display("FAIL oor_st_en got=%0d want=0", en_cnt); end
        checks++; if (timed_out || obs.size() != 1) begin failures++; $display("FAIL oor_st_count got=%0d want=1", obs.size()); end
        else begin
            checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL oor_st_cyc got=%0d want=3", obs[0].cyc); end
        end
        q_cpu.push_back('{1'b0, 32'(4 * DEPTH), 32'h0, 0});
        run_ops(40);
        checks++; if (en_cnt != 0) begin failures++; $display("FAIL oor_ld_en got=%0d want=0", en_cnt); end
        checks++; if (timed_out || obs.size() != 1) begin failures++; $display("FAIL oor_ld_count got=%0d want=1", obs.size()); end
        else begin
            checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL oor_ld_cyc got=%0d want=3", obs[0].cyc); end
            checks++; if (obs[0].rdata !== 32'h0) begin failures++; $display("FAIL oor_ld_rdata got=%h want=0", obs[0].rdata); end
        end
    endtask

    task automatic test_reset_mid();
        int cpu_first;
        drive(0, 1'b1, '{1'b1, 32'h1C, 32'hCAFEF00D, 0});
        tick();
        tick();
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmid_mem_we got=%b want=0", mem_we); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rmid_mem_en got=%b want=0", mem_en); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (cpu_done !== 1'b0 || dma_done !== 1'b0) begin failures++; $display("FAIL rmid_done%0d got=%b%b want=00", c, cpu_done, dma_done); end
            checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata%0d got=%h/%h want=0/0", c, cpu_rdata, dma_rdata); end
            checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rmid_mem%0d got=%b%b want=00", c, mem_en, mem_we); end
            tick();
        end
        mdl_rd = '{32'h0, 32'h0};
        ref_last = 1'b1;
        q_cpu.push_back('{1'b0, 32'h1C, 32'h0, 0});
        q_dma.push_back('{1'b0, 32'h0C, 32'h0, 0});
        run_ops(40);
        cpu_first = -1;
        if (obs.size() > 0) cpu_first = obs[0].port;
        checks++; if (timed_out || cpu_first != 0) begin failures++; $display("FAIL rmid_tie_winner got=%0d want=0", cpu_first); end
        else begin
            checks++; if (obs[0].rdata !== 32'h0) begin failures++; $display("FAIL rmid_aborted_store got=%h want=0", obs[0].rdata); end
        end
    endtask

    task automatic test_random();
        int r, idx, n;
        for (int i = 0; i < 150; i++) begin
            for (int p = 0; p < 2; p++) begin
                r   = $urandom_range(0, 19);
                idx = (r < 16) ? r : (DEPTH - 2 + (r - 16));
                if (p == 0) q_cpu.push_back('{1'($urandom_range(0, 1)), 32'(idx * 4), $urandom, $urandom_range(0, 3)});
                else        q_dma.push_back('{1'($urandom_range(0, 1)), 32'(idx * 4), $urandom, $urandom_range(0, 3)});
            end
        end
        run_ops(5000);
        checks++; if (timed_out || obs.size() != expq.size()) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", obs.size(), expq.size()); end
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs[i].port != expq[i].port || obs[i].cyc != expq[i].cyc || obs[i].rdata !== expq[i].rdata) begin
                failures++;
                $display("FAIL rnd_txn%0d got=p%0d c%0d %h want=p%0d c%0d %h", i, obs[i].port, obs[i].cyc,
                         obs[i].rdata, expq[i].port, expq[i].cyc, expq[i].rdata);
            end
        end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL rnd_stall got=%0d want=0", stall_bad); end
    endtask

`ifdef DM_ALIGN_CHECK_EN
    task automatic test_align();
        q_cpu.push_back('{1'b1, 32'h13, 32'h55AA55AA, 0});
        run_ops(40);
        checks++; if (we_k.size() != 0) begin failures++; $display("FAIL al_write got=%0d want=0", we_k.size()); end
        checks++; if (align_k.size() != 1) begin failures++; $display("FAIL al_pulses got=%0d want=1", align_k.size()); end
        else begin
            checks++; if (align_k[0] != 3) begin failures++; $display("FAIL al_cyc got=%0d want=3", align_k[0]); end
        end
        checks++; if (timed_out || obs.size() != 1) begin failures++; $display("FAIL al_count got=%0d want=1", obs.size()); end
        else begin
            checks++; if (obs[0].cyc != 3) begin failures++; $display("FAIL al_done_cyc got=%0d want=3", obs[0].cyc); end
        end
        q_cpu.push_back('{1'b0, 32'h10, 32'h0, 0});
        run_ops(40);
        checks++; if (align_k.size() != 0) begin failures++; $display("FAIL al_aligned_pulse got=%0d want=0", align_k.size()); end
        checks++; if (obs.size() != 1 || obs[0].rdata !== expq[0].rdata) begin failures++; $display("FAIL al_aligned_load got=%0d want=1", obs.size()); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < DEPTH; i++) env_mem[i] = 32'h0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mdl_rd = '{32'h0, 32'h0};
        ref_last = 1'b1;
        test_reset();
        test_store_load();
        test_tie();
        test_dma_burst();
        test_out_of_range();
        test_reset_mid();
        test_random();
`ifdef DM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
